// File: rtl/comparator_bist.sv
// Exhaustive self-test sweep for a WIDTH-bit magnitude comparator: drives every
// A/B pair, checks EQ/GT/LT against an exact golden compare and counts errors.
module comparator_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  input  logic               dut_eq,
  input  logic               dut_gt,
  input  logic               dut_lt,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH:0]   eq_err,
  output logic [2*WIDTH:0]   gt_err,
  output logic [2*WIDTH:0]   lt_err,
  output logic [2*WIDTH:0]   onehot_err,
  output logic               first_valid,
  output logic [WIDTH-1:0]   first_a,
  output logic [WIDTH-1:0]   first_b
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = IW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [SW-1:0] SETTLE_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1'b1);
  localparam logic [IW-1:0] IDX_LAST    = {IW{1'b1}};
  localparam logic [IW-1:0] IDX_ZERO    = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE     = IW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [WIDTH-1:0] OP_ZERO  = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic [SW-1:0]   settle_r;

  logic            exp_eq_s;
  logic            exp_gt_s;
  logic            exp_lt_s;
  logic            eq_bad_s;
  logic            gt_bad_s;
  logic            lt_bad_s;
  logic            any_bad_s;
  logic            oh_bad_s;

  // True when the three flags do not form exactly one asserted bit.
  function automatic logic not_onehot3(input logic a, input logic b, input logic c);
    logic [1:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {1'b0, c};
    return (sum != 2'd1);
  endfunction

  assign dut_a = idx_r[IW-1:WIDTH];
  assign dut_b = idx_r[WIDTH-1:0];

  // Golden compare on the registered operands and per-output mismatch flags.
  always_comb begin
    exp_eq_s  = (dut_a == dut_b);
    exp_gt_s  = (dut_a >  dut_b);
    exp_lt_s  = (dut_a <  dut_b);
    eq_bad_s  = (dut_eq != exp_eq_s);
    gt_bad_s  = (dut_gt != exp_gt_s);
    lt_bad_s  = (dut_lt != exp_lt_s);
    any_bad_s = eq_bad_s | gt_bad_s | lt_bad_s;
    oh_bad_s  = not_onehot3(dut_eq, dut_gt, dut_lt);
  end

  // Sweep sequencer, error counters and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= IDX_ZERO;
      settle_r    <= SETTLE_ZERO;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_count   <= CNT_ZERO;
      eq_err      <= CNT_ZERO;
      gt_err      <= CNT_ZERO;
      lt_err      <= CNT_ZERO;
      onehot_err  <= CNT_ZERO;
      first_valid <= 1'b0;
      first_a     <= OP_ZERO;
      first_b     <= OP_ZERO;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r     <= S_RUN;
            idx_r       <= IDX_ZERO;
            settle_r    <= SETTLE_ZERO;
            busy        <= 1'b1;
            done        <= 1'b0;
            err_count   <= CNT_ZERO;
            eq_err      <= CNT_ZERO;
            gt_err      <= CNT_ZERO;
            lt_err      <= CNT_ZERO;
            onehot_err  <= CNT_ZERO;
            first_valid <= 1'b0;
            first_a     <= OP_ZERO;
            first_b     <= OP_ZERO;
          end else begin
            state_r <= state_r;
          end
        end
        S_RUN: begin
          if (settle_r == SETTLE_LAST) begin
            // Sample edge: the vector has been held for SETTLE cycles.
            settle_r   <= SETTLE_ZERO;
            err_count  <= err_count  + {{(CW-1){1'b0}}, any_bad_s};
            eq_err     <= eq_err     + {{(CW-1){1'b0}}, eq_bad_s};
            gt_err     <= gt_err     + {{(CW-1){1'b0}}, gt_bad_s};
            lt_err     <= lt_err     + {{(CW-1){1'b0}}, lt_bad_s};
            onehot_err <= onehot_err + {{(CW-1){1'b0}}, oh_bad_s};
            if (any_bad_s && !first_valid) begin
              first_valid <= 1'b1;
              first_a     <= dut_a;
              first_b     <= dut_b;
            end
            if (idx_r == IDX_LAST) begin
              state_r <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end else begin
            settle_r <= settle_r + SETTLE_ONE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_bist.sv
// Self-checking bench for comparator_bist: directed sweeps with modelled comparator
// faults plus random fault tables checked against an exhaustive reference count.
module tb_comparator_bist;

  localparam int W = 4;
  localparam int M_EXACT = 0, M_APPROX = 1, M_EQ0 = 2, M_RAND = 3, M_DELAY = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start3;
  int   mode1, mode3;
  logic [2:0] mask_tbl [256];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [W-1:0] a1, b1, fa1, fb1, a3, b3, fa3, fb3;
  logic         busy1, done1, fv1, busy3, done3, fv3;
  logic [2*W:0] ec1, ee1, ge1, le1, oh1, ec3, ee3, ge3, le3, oh3;
  logic [2:0]   comb1, p1a, p1b, out1, comb3, p3a, p3b, out3;

  // Comparator-under-test behaviours; result packed as {eq, gt, lt}.
  function automatic logic [2:0] cmp_fn(input int mode, input logic [3:0] a, input logic [3:0] b);
    logic [2:0] r;
    r = {a == b, a > b, a < b};
    case (mode)
      M_APPROX: r = {a[3:1] == b[3:1], a[3:1] > b[3:1], a[3:1] < b[3:1]};
      M_EQ0:    r[2] = 1'b0;
      M_RAND:   r = r ^ mask_tbl[{a, b}];
      default:  r = r;
    endcase
    return r;
  endfunction

  always_comb begin
    comb1 = cmp_fn(mode1, a1, b1);
    out1  = (mode1 == M_DELAY) ? p1b : comb1;
    comb3 = cmp_fn(mode3, a3, b3);
    out3  = (mode3 == M_DELAY) ? p3b : comb3;
  end

  always @(posedge clk) begin
    p1a <= comb1; p1b <= p1a;
    p3a <= comb3; p3b <= p3a;
  end

  comparator_bist #(.WIDTH(W), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1),
    .dut_eq(out1[2]), .dut_gt(out1[1]), .dut_lt(out1[0]),
    .busy(busy1), .done(done1), .err_count(ec1), .eq_err(ee1), .gt_err(ge1),
    .lt_err(le1), .onehot_err(oh1), .first_valid(fv1), .first_a(fa1), .first_b(fb1));

  comparator_bist #(.WIDTH(W), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .dut_a(a3), .dut_b(b3),
    .dut_eq(out3[2]), .dut_gt(out3[1]), .dut_lt(out3[0]),
    .busy(busy3), .done(done3), .err_count(ec3), .eq_err(ee3), .gt_err(ge3),
    .lt_err(le3), .onehot_err(oh3), .first_valid(fv3), .first_a(fa3), .first_b(fb3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk all 256 vectors in sweep order and tally what a checker must count.
  task automatic ref_model(input int mode, output int e_err, output int e_eq, output int e_gt,
                           output int e_lt, output int e_oh, output int e_fv, output int e_fa,
                           output int e_fb);
    logic [2:0] g, o;
    e_err = 0; e_eq = 0; e_gt = 0; e_lt = 0; e_oh = 0; e_fv = 0; e_fa = 0; e_fb = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        g = {a == b, a > b, a < b};
        o = cmp_fn(mode, 4'(a), 4'(b));
        if (o[2] != g[2]) e_eq++;
        if (o[1] != g[1]) e_gt++;
        if (o[0] != g[0]) e_lt++;
        if (o != g) begin
          e_err++;
          if (e_fv == 0) begin e_fv = 1; e_fa = a; e_fb = b; end
        end
        if (int'(o[2]) + int'(o[1]) + int'(o[0]) != 1) e_oh++;
      end
    end
  endtask

  task automatic pulse_start1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  // Counts RUN cycles from the current one; optionally pokes start at a given cycle.
  task automatic wait_done1(input int poke_at, output int cycles);
    cycles = 0;
    while (busy1 === 1'b1 && cycles < 2000) begin
      cycles++;
      if (cycles == poke_at) start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
    end
  endtask

  task automatic chk_counts1(input string tag, input int e_err, input int e_eq, input int e_gt,
                             input int e_lt, input int e_oh, input int e_fv, input int e_fa,
                             input int e_fb);
    chk({tag, ".err_count"}, 32'(ec1), e_err);
    chk({tag, ".eq_err"}, 32'(ee1), e_eq);
    chk({tag, ".gt_err"}, 32'(ge1), e_gt);
    chk({tag, ".lt_err"}, 32'(le1), e_lt);
    chk({tag, ".onehot_err"}, 32'(oh1), e_oh);
    chk({tag, ".first_valid"}, 32'(fv1), e_fv);
    chk({tag, ".first_a"}, 32'(fa1), e_fa);
    chk({tag, ".first_b"}, 32'(fb1), e_fb);
  endtask

  initial begin
    int cyc;
    int r_err, r_eq, r_gt, r_lt, r_oh, r_fv, r_fa, r_fb;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    mode1 = M_EXACT; mode3 = M_EXACT;
    for (int k = 0; k < 256; k++) mask_tbl[k] = 3'b000;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.busy", 32'(busy1), 0);
    chk("reset.done", 32'(done1), 0);
    chk("reset.dut_a", 32'(a1), 0);
    chk_counts1("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // Exact comparator: clean sweep of 256 cycles.
    pulse_start1();
    chk("exact.busy_after_start", 32'(busy1), 1);
    chk("exact.done_after_start", 32'(done1), 0);
    wait_done1(0, cyc);
    chk("exact.sweep_len", cyc, 256);
    chk("exact.done", 32'(done1), 1);
    chk("exact.last_a", 32'(a1), 15);
    chk("exact.last_b", 32'(b1), 15);
    chk_counts1("exact", 0, 0, 0, 0, 0, 0, 0, 0);

    // Approximate comparator ignoring the LSB.
    mode1 = M_APPROX;
    pulse_start1();
    wait_done1(0, cyc);
    chk("approx.sweep_len", cyc, 256);
    chk_counts1("approx", 16, 16, 8, 8, 0, 1, 0, 1);

    // EQ stuck at 0.
    mode1 = M_EQ0;
    pulse_start1();
    wait_done1(0, cyc);
    chk_counts1("eq0", 16, 16, 0, 0, 16, 1, 0, 0);

    // SETTLE=3: vectors held 3 cycles, 768-cycle sweep, tolerates 2-cycle latency.
    mode3 = M_DELAY;
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    chk("s3.b_cycle1", 32'(b3), 0);
    @(negedge clk);
    @(negedge clk);
    chk("s3.b_cycle3", 32'(b3), 0);
    @(negedge clk);
    chk("s3.b_cycle4", 32'(b3), 1);
    cyc = 4;
    while (busy3 === 1'b1 && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    chk("s3.sweep_len", cyc - 1, 768);
    chk("s3.done", 32'(done3), 1);
    chk("s3.err_count", 32'(ec3), 0);
    chk("s3.onehot_err", 32'(oh3), 0);
    chk("s3.first_valid", 32'(fv3), 0);

    // Same delayed comparator at SETTLE=1 must show errors.
    mode1 = M_DELAY;
    pulse_start1();
    wait_done1(0, cyc);
    chk("delay_s1.err_nonzero", 32'(ec1 != '0), 1);

    // Reset mid-sweep at cycle 100.
    mode1 = M_APPROX;
    pulse_start1();
    cyc = 1;
    while (cyc < 100) begin cyc++; @(negedge clk); end
    chk("midrst.a_cycle100", 32'(a1), 6);
    chk("midrst.b_cycle100", 32'(b1), 3);
    chk("midrst.errs_before", 32'(ec1 != '0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", 32'(busy1), 0);
    chk("midrst.done", 32'(done1), 0);
    chk("midrst.dut_a", 32'(a1), 0);
    chk("midrst.dut_b", 32'(b1), 0);
    chk_counts1("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
    mode1 = M_EXACT;
    pulse_start1();
    wait_done1(0, cyc);
    chk("midrst.fresh_len", cyc, 256);
    chk_counts1("midrst.fresh", 0, 0, 0, 0, 0, 0, 0, 0);

    // start during RUN is ignored; start in DONE restarts with identical results.
    mode1 = M_APPROX;
    pulse_start1();
    wait_done1(50, cyc);
    chk("restart.ignored_len", cyc, 256);
    chk_counts1("restart.first", 16, 16, 8, 8, 0, 1, 0, 1);
    pulse_start1();
    chk("restart.cleared", 32'(ec1), 0);
    chk("restart.fv_cleared", 32'(fv1), 0);
    wait_done1(0, cyc);
    chk("restart.second_len", cyc, 256);
    chk_counts1("restart.second", 16, 16, 8, 8, 0, 1, 0, 1);

    // Random fault tables against the reference tally.
    for (int round = 0; round < 4; round++) begin
      for (int k = 0; k < 256; k++)
        mask_tbl[k] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      mode1 = M_RAND;
      ref_model(M_RAND, r_err, r_eq, r_gt, r_lt, r_oh, r_fv, r_fa, r_fb);
      pulse_start1();
      wait_done1(0, cyc);
      chk($sformatf("rand%0d.len", round), cyc, 256);
      chk_counts1($sformatf("rand%0d", round), r_err, r_eq, r_gt, r_lt, r_oh, r_fv, r_fa, r_fb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
